booth_seq_multiplier: RTL and testbench

//  Iterative radix-2 Booth multiplier for signed two's-complement operands.

---
 rtl/booth_seq_multiplier.sv | 114 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: iterative radix-2 Booth multiplier for signed operands,
// with valid/ready handshakes on both the operand and the product side.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   m_q, q_q;
    logic [WIDTH:0]     a_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic               ready_q, valid_q, busy_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH:0]     m_sx, addend, sum, acc, a_d;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH:0]     carry;
    logic               carry_unused, sub, add;

    assign sub      = q_q[0] & ~qm1_q;
    assign add      = ~q_q[0] & qm1_q;
    assign m_sx     = {m_q[WIDTH-1], m_q};
    assign addend   = sub ? ~m_sx : m_sx;
    assign carry[0] = sub;

    // Guard bit in A keeps -2^(WIDTH-1) exact when it is subtracted.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        if (i == WIDTH) begin : g_top
            full_adder u_fa (.a_i(a_q[i]), .b_i(addend[i]), .c_i(carry[i]), .s_o(sum[i]), .c_o(carry_unused));
        end else begin : g_mid
            full_adder u_fa (.a_i(a_q[i]), .b_i(addend[i]), .c_i(carry[i]), .s_o(sum[i]), .c_o(carry[i+1]));
        end
    end

    assign acc = (sub | add) ? sum : a_q;
    assign a_d = {acc[WIDTH], acc[WIDTH:1]};
    assign q_d = {acc[0], q_q[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    m_q     <= i_multiplicand;
                    q_q     <= i_multiplier;
                    a_q     <= '0;
                    qm1_q   <= 1'b0;
                    cnt_q   <= CW'(WIDTH);
                    state_q <= CALC;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= q_q[0];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b1;
                        product_q <= {a_d[WIDTH-1:0], q_d};
                    end
                end
                DONE: if (i_ready) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_product = product_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: table vectors, handshake corner cases and random
// products for WIDTH=8 and WIDTH=4, checked through expected-product queues.
module tb_booth_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0, i_ready = 1'b1;
    logic [7:0]  mcand = '0, mplier = '0;
    logic        o_ready, o_valid, o_busy;
    logic [15:0] product;
    logic        valid4 = 1'b0, ready4 = 1'b1;
    logic [3:0]  m4 = '0, q4 = '0;
    logic        o_ready4, o_valid4, o_busy4;
    logic [7:0]  product4;

    int pass_cnt = 0, total = 0, cyc = 0;
    logic [15:0] sb[$];
    logic [7:0]  sb4[$];

    typedef struct {logic [7:0] m; logic [7:0] q; logic [15:0] p;} vec_t;
    vec_t tv[11];

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_multiplicand(mcand), .i_multiplier(mplier), .o_valid(o_valid),
        .i_ready(i_ready), .o_product(product), .o_busy(o_busy)
    );

    booth_seq_multiplier #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid4), .o_ready(o_ready4),
        .i_multiplicand(m4), .i_multiplier(q4), .o_valid(o_valid4),
        .i_ready(ready4), .o_product(product4), .o_busy(o_busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && o_valid && i_ready) begin
            total++;
            if (sb.size() == 0) $display("FAIL sb8_unexpected product=%h", product);
            else begin
                e = sb.pop_front();
                if (product === e) pass_cnt++;
                else $display("FAIL sb8_product got=%h exp=%h", product, e);
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && o_valid4 && ready4) begin
            total++;
            if (sb4.size() == 0) $display("FAIL sb4_unexpected product=%h", product4);
            else begin
                e = sb4.pop_front();
                if (product4 === e) pass_cnt++;
                else $display("FAIL sb4_product got=%h exp=%h", product4, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    task automatic send(input logic [7:0] m, input logic [7:0] q, input logic [15:0] e);
        int n = 0;
        while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("accept_ready", {31'd0, o_ready}, 1);
        if (!o_ready) return;
        mcand = m; mplier = q; i_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 50) begin @(posedge clk); #1; n++; end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || sb4.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
        chk("sb_drained", sb.size() + sb4.size(), 0);
    endtask

    initial begin
        int n, t, t_prev;
        logic ok;
        logic signed [7:0]  rm, rq;
        logic signed [15:0] e;
        logic signed [3:0]  rm4, rq4;
        logic signed [7:0]  e4;
        tv = '{'{8'h07, 8'h03, 16'h0015}, '{8'h80, 8'h80, 16'h4000}, '{8'h80, 8'h7F, 16'hC080},
               '{8'hFF, 8'hFF, 16'h0001}, '{8'h00, 8'hB3, 16'h0000}, '{8'h7F, 8'h7F, 16'h3F01},
               '{8'h80, 8'h01, 16'hFF80}, '{8'h01, 8'h80, 16'hFF80}, '{8'h7F, 8'h80, 16'hC080},
               '{8'h05, 8'hFA, 16'hFFE2}, '{8'hFF, 8'h7F, 16'hFF81}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, o_ready}, 1);
        chk("rst_valid", {31'd0, o_valid}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);
        chk("rst_product", {16'd0, product}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tv[i]) begin
            send(tv[i].m, tv[i].q, tv[i].p);
            chk("busy_calc", {30'd0, o_busy, o_ready}, 2'b10);
            wait_valid(n);
            chk("latency", n, 8);
            @(posedge clk); #1;
            chk("ready_after", {30'd0, o_ready, o_valid}, 2'b10);
        end
        drain();

        // backpressure: product held while the consumer stalls, new operands ignored
        i_ready = 1'b0;
        send(8'h05, 8'hFA, 16'hFFE2);
        wait_valid(n);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_valid = (k % 3 == 0);
            mcand = 8'd99; mplier = 8'd99;
            @(negedge clk);
            ok &= o_valid && product == 16'hFFE2 && !o_ready && o_busy;
            @(posedge clk); #1;
        end
        chk("bp_hold", {31'd0, ok}, 1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'd0, o_ready, o_valid}, 2'b10);
        ok = 1'b1;
        repeat (12) begin @(posedge clk); #1; ok &= !o_valid; end
        chk("bp_no_extra", {31'd0, ok}, 1);
        drain();

        // reset in the middle of CALC
        send(8'h07, 8'h03, 16'h0015);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {12'd0, o_ready, o_valid, o_busy, 1'b0, product}, {12'd0, 4'b1000, 16'h0000});
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        ok = 1'b1;
        repeat (20) begin @(posedge clk); #1; ok &= !o_valid && o_ready; end
        chk("midrst_no_valid", {31'd0, ok}, 1);

        // back-to-back with i_valid held high
        i_valid = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            mcand = tv[k + 1].m; mplier = tv[k + 1].q;
            n = 0;
            while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
            sb.push_back(tv[k + 1].p);
            t = cyc;
            if (k > 0) chk("b2b_spacing", t - t_prev, 10);
            t_prev = t;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        drain();

        for (int k = 0; k < 2000; k++) begin
            rm = 8'($urandom); rq = 8'($urandom);
            e = rm * rq;
            send(rm, rq, e);
        end
        drain();

        for (int k = 0; k < 2000; k++) begin
            rm4 = 4'($urandom); rq4 = 4'($urandom);
            e4 = rm4 * rq4;
            n = 0;
            while (!o_ready4 && n < 100) begin @(posedge clk); #1; n++; end
            m4 = rm4; q4 = rq4; valid4 = 1'b1;
            sb4.push_back(e4);
            @(posedge clk); #1;
            valid4 = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
